// File: rtl/mu0_mem_arbiter.sv
// Two-port arbiter for the single-port MU0 RAM: port 0 is the CPU, port 1 the loader/debug port.
// Each access is an issue (ACCESS) cycle followed by an ack (RESP) cycle that also re-arbitrates.
module mu0_mem_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_write,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_write,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                gnt_port_q;
  logic                lock_valid_q;
  logic                lock_port_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic [DATA_W-1:0]   mem_writedata_q;

  logic                decide;
  logic                elig0;
  logic                elig1;
  logic                grant_valid;
  logic                grant_port;
  logic                lock_clear;
  logic                owner_lock;
  logic                owner_req;
  logic [ADDR_W-1:0]   g_addr;
  logic                g_write;
  logic                g_lock;
  logic [DATA_W-1:0]   g_wdata;

  // Arbitration decision, evaluated in IDLE and in RESP.
  always_comb begin
    decide      = (state_q == StIdle) || (state_q == StResp);
    elig0       = p0_req && !((state_q == StResp) && (gnt_port_q == 1'b0));
    elig1       = p1_req && !((state_q == StResp) && (gnt_port_q == 1'b1));
    if (lock_valid_q) begin
      if (lock_port_q) begin
        elig0 = 1'b0;
      end else begin
        elig1 = 1'b0;
      end
    end
    grant_valid = decide && (elig0 || elig1);
    if (elig0 && elig1) begin
      grant_port = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      grant_port = elig1;
    end
    g_addr     = grant_port ? p1_addr  : p0_addr;
    g_write    = grant_port ? p1_write : p0_write;
    g_lock     = grant_port ? p1_lock  : p0_lock;
    g_wdata    = grant_port ? p1_wdata : p0_wdata;
    owner_lock = lock_port_q ? p1_lock : p0_lock;
    owner_req  = lock_port_q ? p1_req  : p0_req;
    lock_clear = decide && lock_valid_q && !owner_lock && !owner_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      last_grant_q    <= 1'b1;
      gnt_port_q      <= 1'b0;
      lock_valid_q    <= 1'b0;
      lock_port_q     <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata0_q        <= '0;
      rdata1_q        <= '0;
      mem_address_q   <= '0;
      mem_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_writedata_q <= '0;
    end else begin
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      mem_address_q   <= '0;
      mem_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_writedata_q <= '0;
      unique case (state_q)
        StIdle, StResp: begin
          if (grant_valid) begin
            state_q         <= StAccess;
            gnt_port_q      <= grant_port;
            last_grant_q    <= grant_port;
            lock_valid_q    <= g_lock;
            lock_port_q     <= grant_port;
            mem_address_q   <= g_addr;
            mem_write_q     <= g_write;
            mem_read_q      <= !g_write;
            mem_writedata_q <= g_wdata;
          end else begin
            state_q <= StIdle;
            if (lock_clear) begin
              lock_valid_q <= 1'b0;
            end
          end
        end
        StAccess: begin
          state_q <= StResp;
          if (gnt_port_q) begin
            ack1_q <= 1'b1;
            if (mem_read_q) begin
              rdata1_q <= mem_readdata;
            end
          end else begin
            ack0_q <= 1'b1;
            if (mem_read_q) begin
              rdata0_q <= mem_readdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are gated by rst_n so a reset during ACCESS suppresses the RAM write at that edge.
  assign mem_write     = mem_write_q & rst_n;
  assign mem_read      = mem_read_q & rst_n;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign p0_ack        = ack0_q;
  assign p1_ack        = ack1_q;
  assign p0_rdata      = rdata0_q;
  assign p1_rdata      = rdata1_q;
  assign busy          = (state_q == StAccess) || (state_q == StResp);

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Directed bench for mu0_mem_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own RAM model that presents read data during the ACCESS cycle.
module tb_mu0_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_write, p0_lock;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p1_req, p1_write, p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;

  logic          rr_p0_ack, rr_p1_ack, rr_mem_write, rr_mem_read, rr_busy;
  logic [DW-1:0] rr_p0_rdata, rr_p1_rdata, rr_mem_wdata, rr_mem_rdata;
  logic [AW-1:0] rr_mem_addr;
  logic          fp_p0_ack, fp_p1_ack, fp_mem_write, fp_mem_read, fp_busy;
  logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata, fp_mem_rdata;
  logic [AW-1:0] fp_mem_addr;

  logic [DW-1:0] ram_rr [0:(1<<AW)-1];
  logic [DW-1:0] ram_fp [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mu0_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(rr_p0_ack), .p0_rdata(rr_p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(rr_p1_ack), .p1_rdata(rr_p1_rdata),
    .mem_address(rr_mem_addr), .mem_write(rr_mem_write), .mem_read(rr_mem_read),
    .mem_writedata(rr_mem_wdata), .mem_readdata(rr_mem_rdata), .busy(rr_busy)
  );

  mu0_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata),
    .mem_address(fp_mem_addr), .mem_write(fp_mem_write), .mem_read(fp_mem_read),
    .mem_writedata(fp_mem_wdata), .mem_readdata(fp_mem_rdata), .busy(fp_busy)
  );

  assign rr_mem_rdata = ram_rr[rr_mem_addr];
  assign fp_mem_rdata = ram_fp[fp_mem_addr];

  always @(posedge clk) begin
    if (rr_mem_write) ram_rr[rr_mem_addr] <= rr_mem_wdata;
    if (fp_mem_write) ram_fp[fp_mem_addr] <= fp_mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One uncontested access on the RR instance: grant, ACCESS checks, ack checks, back to idle.
  task automatic run_single(input bit port, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    if (port) begin
      p1_req = 1'b1; p1_write = wr; p1_addr = addr; p1_wdata = wd; p1_lock = 1'b0;
    end else begin
      p0_req = 1'b1; p0_write = wr; p0_addr = addr; p0_wdata = wd; p0_lock = 1'b0;
    end
    step();
    check("acc_addr", 32'(rr_mem_addr), 32'(addr));
    check("acc_write", 32'(rr_mem_write), 32'(wr));
    check("acc_read", 32'(rr_mem_read), 32'(!wr));
    check("acc_ack0", 32'(rr_p0_ack), 32'd0);
    if (wr) check("acc_wdata", 32'(rr_mem_wdata), 32'(wd));
    // Drop req and scramble the request after the grant: the latched copy must be used.
    if (port) begin
      p1_req = 1'b0; p1_addr = ~addr; p1_wdata = ~wd; p1_write = ~wr;
    end else begin
      p0_req = 1'b0; p0_addr = ~addr; p0_wdata = ~wd; p0_write = ~wr;
    end
    step();
    check("resp_ack0", 32'(rr_p0_ack), 32'(!port));
    check("resp_ack1", 32'(rr_p1_ack), 32'(port));
    check("resp_mem_write", 32'(rr_mem_write), 32'd0);
    check("resp_mem_addr", 32'(rr_mem_addr), 32'd0);
    if (!wr) check("resp_rdata", port ? 32'(rr_p1_rdata) : 32'(rr_p0_rdata), 32'(exp_rd));
    step();
    check("idle_ack", 32'(rr_p0_ack | rr_p1_ack), 32'd0);
    check("idle_busy", 32'(rr_busy), 32'd0);
  endtask

  // Expected tables for the lock sequence, indexed by edge 1..10.
  logic [10:0] lk_ack0   = 11'b100_0000_0000;
  logic [10:0] lk_ack1   = 11'b001_0010_0100;
  logic [10:0] lk_wr     = 11'b000_1001_0010;
  logic [10:0] lk_rd     = 11'b010_0000_0000;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_rr[i] = '0;
      ram_fp[i] = '0;
    end
    ram_rr[5] = 16'h1234;
    ram_fp[5] = 16'h1234;
    p0_req = 0; p0_write = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_write = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;

    // Reset state.
    do_reset();
    check("rst_ack0", 32'(rr_p0_ack), 32'd0);
    check("rst_ack1", 32'(rr_p1_ack), 32'd0);
    check("rst_rdata0", 32'(rr_p0_rdata), 32'd0);
    check("rst_rdata1", 32'(rr_p1_rdata), 32'd0);
    check("rst_mem_rw", 32'({rr_mem_read, rr_mem_write}), 32'd0);
    check("rst_mem_addr", 32'(rr_mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(rr_mem_wdata), 32'd0);
    check("rst_busy", 32'(rr_busy), 32'd0);
    step();

    // Single read, then p1 write followed by p0 read of the same word.
    run_single(1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234);
    run_single(1'b1, 1'b1, 12'h0A0, 16'hBEEF, 16'h0000);
    check("wr_keeps_rdata0", 32'(rr_p0_rdata), 32'h1234);
    run_single(1'b0, 1'b0, 12'h0A0, 16'h0000, 16'hBEEF);
    check("p1_rdata_zero", 32'(rr_p1_rdata), 32'd0);

    // Both held: alternating grants, p0 first after reset, ack every 2 cycles.
    do_reset();
    p0_req = 1; p0_write = 0; p0_addr = 12'h005;
    p1_req = 1; p1_write = 0; p1_addr = 12'h0A0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("alt_ack0_%0d", k), 32'(rr_p0_ack), 32'(k == 2 || k == 6));
      check($sformatf("alt_ack1_%0d", k), 32'(rr_p1_ack), 32'(k == 4 || k == 8));
      check($sformatf("alt_addr_%0d", k), 32'(rr_mem_addr),
            (k % 2 == 0) ? 32'd0 : ((k % 4 == 1) ? 32'h005 : 32'h0A0));
      check($sformatf("alt_fp_ack0_%0d", k), 32'(fp_p0_ack), 32'(k == 2 || k == 6));
      check($sformatf("alt_busy_%0d", k), 32'(rr_busy), 32'd1);
      if (k == 2) check("alt_rdata0", 32'(rr_p0_rdata), 32'h1234);
      if (k == 4) check("alt_rdata1", 32'(rr_p1_rdata), 32'hBEEF);
      if (k == 8) begin
        p0_req = 0; p1_req = 0;
      end
    end
    step();
    check("alt_end_busy", 32'(rr_busy), 32'd0);

    // last_grant = p0, then a contested IDLE decision: RR picks p1, fixed priority picks p0.
    run_single(1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234);
    p0_req = 1; p0_write = 0; p0_addr = 12'h005;
    p1_req = 1; p1_write = 0; p1_addr = 12'h0A0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("prio_rr_addr_%0d", k), 32'(rr_mem_addr),
            (k == 1) ? 32'h0A0 : (k == 3) ? 32'h005 : 32'd0);
      check($sformatf("prio_fp_addr_%0d", k), 32'(fp_mem_addr),
            (k == 1) ? 32'h005 : (k == 3) ? 32'h0A0 : 32'd0);
      check($sformatf("prio_rr_ack_%0d", k), 32'({rr_p0_ack, rr_p1_ack}),
            (k == 2) ? 32'b01 : (k == 4) ? 32'b10 : 32'b00);
      check($sformatf("prio_fp_ack_%0d", k), 32'({fp_p0_ack, fp_p1_ack}),
            (k == 2) ? 32'b10 : (k == 4) ? 32'b01 : 32'b00);
    end
    p0_req = 0; p1_req = 0;
    step();

    // p1 locks for three writes while p0 waits; p0 granted once p1 issues an unlocked access.
    do_reset();
    p1_req = 1; p1_write = 1; p1_lock = 1; p1_addr = 12'h100; p1_wdata = 16'h0001;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("lk_ack0_%0d", k), 32'(rr_p0_ack), 32'(lk_ack0[k]));
      check($sformatf("lk_ack1_%0d", k), 32'(rr_p1_ack), 32'(lk_ack1[k]));
      check($sformatf("lk_wr_%0d", k), 32'(rr_mem_write), 32'(lk_wr[k]));
      check($sformatf("lk_rd_%0d", k), 32'(rr_mem_read), 32'(lk_rd[k]));
      check($sformatf("lk_fp_ack0_%0d", k), 32'(fp_p0_ack), 32'(lk_ack0[k]));
      if (k == 1) begin
        p0_req = 1; p0_write = 0; p0_lock = 0; p0_addr = 12'h005;
        p1_addr = 12'h101; p1_wdata = 16'h0002;
      end
      if (k == 4) begin
        p1_addr = 12'h102; p1_wdata = 16'h0003; p1_lock = 0;
      end
      if (k == 7) check("lk_addr3", 32'(rr_mem_addr), 32'h102);
      if (k == 8) p1_req = 0;
      if (k == 9) check("lk_addr_p0", 32'(rr_mem_addr), 32'h005);
      if (k == 10) begin
        check("lk_rdata0", 32'(rr_p0_rdata), 32'h1234);
        p0_req = 0;
      end
    end
    check("lk_ram", 32'({ram_rr[12'h100], ram_rr[12'h101]}), 32'h0001_0002);
    check("lk_ram3", 32'(ram_rr[12'h102]), 32'h0003);
    step();

    // Reset during ACCESS of a p0 write: no ack, strobe gone, RAM untouched.
    p0_req = 1; p0_write = 1; p0_addr = 12'h200; p0_wdata = 16'hDEAD;
    step();
    check("ab_acc_write", 32'(rr_mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_strobe_gated", 32'(rr_mem_write), 32'd0);
    step();
    check("ab_ack0", 32'(rr_p0_ack), 32'd0);
    check("ab_busy", 32'(rr_busy), 32'd0);
    check("ab_mem_write", 32'(rr_mem_write), 32'd0);
    p0_req = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ab_no_ack_%0d", k), 32'(rr_p0_ack | fp_p0_ack), 32'd0);
    end
    check("ab_ram", 32'(ram_rr[12'h200]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
